// File: rtl/pc_reg.sv
// Program counter with stall/flush/branch handling and a one-deep pending-redirect latch.
// Optional fetch alignment check enabled by defining PC_ALIGN_CHK_EN.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic [31:0] pc,
  output logic        ce,
  output logic        pc_misalign_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    HOLD      = 2'd2,
    HOLD_PEND = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg_q, pc_next;
  logic [31:0] pend_target_reg, pend_target_next;
  logic        pend_valid_reg, pend_valid_next;
  logic        ce_reg, misalign_reg;
  logic        misalign_next;
  logic        unused_stall;

  // Only stage 0 of the stall vector affects fetch.
  assign unused_stall = ^stall[5:1];

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg_q;
    pend_target_next = pend_target_reg;
    pend_valid_next  = pend_valid_reg;
    if (state_reg == IDLE) begin
      // First fetch after reset release is RESET_PC itself.
      state_next = RUN;
    end else if (flush) begin
      pc_next          = new_pc;
      pend_target_next = 32'h0;
      pend_valid_next  = 1'b0;
      state_next       = RUN;
    end else if (stall[0]) begin
      if (branch_flag_i) begin
        pend_target_next = branch_target_address_i;
        pend_valid_next  = 1'b1;
        state_next       = HOLD_PEND;
      end else if (state_reg != HOLD_PEND) begin
        state_next = HOLD;
      end
    end else begin
      if (branch_flag_i)
        pc_next = branch_target_address_i;
      else if (state_reg == HOLD_PEND && pend_valid_reg)
        pc_next = pend_target_reg;
      else
        pc_next = pc_reg_q + 32'd4;
      pend_target_next = 32'h0;
      pend_valid_next  = 1'b0;
      state_next       = RUN;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  assign misalign_next = (pc_next[1:0] != 2'b00);
`else
  assign misalign_next = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg_q        <= RESET_PC;
      pend_target_reg <= 32'h0;
      pend_valid_reg  <= 1'b0;
      ce_reg          <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg_q        <= pc_next;
      pend_target_reg <= pend_target_next;
      pend_valid_reg  <= pend_valid_next;
      // A misaligned fetch is suppressed so the ROM returns a nop.
      ce_reg          <= (state_next != IDLE) && !misalign_next;
      misalign_reg    <= misalign_next;
    end
  end

  assign pc            = pc_reg_q;
  assign ce            = ce_reg;
  assign pc_misalign_o = misalign_reg;

endmodule
